threshold_stream_loader: RTL and testbench

THRESHOLD_STREAM_LOADER -- requirements
Module: threshold_stream_loader

---
 rtl/threshold_stream_loader.sv | 143 ++++++++++++++
 tb/tb_threshold_stream_loader.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_stream_loader.sv
// Streams C*(2**N-1) threshold words from AXI-Stream into an AXI-lite slave,
// one write at a time, addressed by channel (split into PE lane and fold) and index.
module threshold_stream_loader #(
  parameter int unsigned N  = 4,
  parameter int unsigned C  = 6,
  parameter int unsigned PE = 3,
  localparam int unsigned A = $clog2(C / PE) + $clog2(PE) + N + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [31:0]  s_axis_tdata,
  output logic         m_axilite_AWVALID,
  input  logic         m_axilite_AWREADY,
  output logic [A-1:0] m_axilite_AWADDR,
  output logic         m_axilite_WVALID,
  input  logic         m_axilite_WREADY,
  output logic [31:0]  m_axilite_WDATA,
  output logic [3:0]   m_axilite_WSTRB,
  input  logic         m_axilite_BVALID,
  output logic         m_axilite_BREADY,
  input  logic [1:0]   m_axilite_BRESP
);

  localparam int unsigned PEW  = $clog2(PE);
  localparam int unsigned CW   = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0]  IMAX = N'(2 ** N - 2);
  localparam logic [CW-1:0] CMAX = CW'(C - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [CW-1:0] r_c, w_nxt_c;
  logic [N-1:0]  r_i, w_nxt_i;
  logic [31:0]   r_data, w_nxt_data;
  logic          r_err, w_nxt_err;
  logic          r_awvalid, w_nxt_awvalid;
  logic          r_wvalid, w_nxt_wvalid;
  logic [31:0]   w_c32;
  logic [A-1:0]  w_addr;

  // Address: {c / PE, c mod PE, i, 2'b00}; empty fields collapse to zero
  assign w_c32  = 32'(r_c);
  assign w_addr = (A'(r_i) << 2)
                | (A'(w_c32 % PE) << (N + 2))
                | (A'(w_c32 / PE) << (N + 2 + PEW));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_c       <= '0;
      r_i       <= '0;
      r_err     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_c       <= w_nxt_c;
      r_i       <= w_nxt_i;
      r_err     <= w_nxt_err;
      r_awvalid <= w_nxt_awvalid;
      r_wvalid  <= w_nxt_wvalid;
    end
  end

  // Payload register is only meaningful while WVALID is high, so it carries no reset
  always_ff @(posedge clk) begin
    r_data <= w_nxt_data;
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_c       = r_c;
    w_nxt_i       = r_i;
    w_nxt_data    = r_data;
    w_nxt_err     = r_err;
    w_nxt_awvalid = r_awvalid;
    w_nxt_wvalid  = r_wvalid;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nxt_state = FETCH;
          w_nxt_c     = '0;
          w_nxt_i     = '0;
          w_nxt_err   = 1'b0;
        end
      end
      FETCH: begin
        if (s_axis_tvalid) begin
          w_nxt_data    = s_axis_tdata;
          w_nxt_awvalid = 1'b1;
          w_nxt_wvalid  = 1'b1;
          w_nxt_state   = ISSUE;
        end
      end
      ISSUE: begin
        if (r_awvalid && m_axilite_AWREADY) w_nxt_awvalid = 1'b0;
        if (r_wvalid && m_axilite_WREADY)   w_nxt_wvalid  = 1'b0;
        if (!w_nxt_awvalid && !w_nxt_wvalid) w_nxt_state = RESP;
      end
      RESP: begin
        if (m_axilite_BVALID) begin
          if (m_axilite_BRESP != 2'b00) w_nxt_err = 1'b1;
          if (r_c == CMAX && r_i == IMAX) begin
            w_nxt_state = DONE;
          end else begin
            w_nxt_state = FETCH;
            if (r_i == IMAX) begin
              w_nxt_i = '0;
              w_nxt_c = r_c + CW'(1);
            end else begin
              w_nxt_i = r_i + N'(1);
            end
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign busy              = (r_state == FETCH) || (r_state == ISSUE) || (r_state == RESP);
  assign done              = (r_state == DONE);
  assign err               = r_err;
  assign s_axis_tready     = (r_state == FETCH);
  assign m_axilite_AWVALID = r_awvalid;
  assign m_axilite_AWADDR  = w_addr;
  assign m_axilite_WVALID  = r_wvalid;
  assign m_axilite_WDATA   = r_data;
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = (r_state == RESP);

endmodule

// File: tb/tb_threshold_stream_loader.sv
// Bench for threshold_stream_loader at default parameters: a stream source and
// AXI-lite slave run in the background; tasks compare logged writes to a model.
module tb_threshold_stream_loader;

  localparam int unsigned A     = 9;
  localparam int unsigned NWR   = 90;
  localparam int unsigned ENT   = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic         tvalid, tready;
  logic [31:0]  tdata;
  logic         awvalid, awready;
  logic [A-1:0] awaddr;
  logic         wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         bvalid, bready;
  logic [1:0]   bresp;

  int total = 0;
  int bad   = 0;

  logic [31:0]  src_q[$];
  logic [31:0]  exp_vals[$];
  logic [A-1:0] got_addr[$];
  logic [31:0]  got_data[$];
  int n_consumed = 0;
  int gap = 0;
  int gap_cnt = 0;
  bit src_fire = 0;

  int slave_mode = 0;
  bit b_rand = 0;
  int err_at = -1;
  int hold_at = -1;
  int nb = 0;
  bit aw_got = 0, w_got = 0, aw_wait = 0, w_wait = 0, b_arm = 0, b_fire = 0;
  bit aw_ok, w_ok;
  int since_aw = 0, since_w = 0, b_cnt = 0;
  logic [A-1:0] aw_hold;
  logic [31:0]  w_hold;

  threshold_stream_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .s_axis_tvalid     (tvalid),
    .s_axis_tready     (tready),
    .s_axis_tdata      (tdata),
    .m_axilite_AWVALID (awvalid),
    .m_axilite_AWREADY (awready),
    .m_axilite_AWADDR  (awaddr),
    .m_axilite_WVALID  (wvalid),
    .m_axilite_WREADY  (wready),
    .m_axilite_WDATA   (wdata),
    .m_axilite_WSTRB   (wstrb),
    .m_axilite_BVALID  (bvalid),
    .m_axilite_BREADY  (bready),
    .m_axilite_BRESP   (bresp)
  );

  always #5 clk = ~clk;

  // Write k targets channel c = k/15, index i = k%15; channel splits into fold c/3 and lane c%3
  function automatic logic [A-1:0] model_addr(input int k);
    int c, i;
    c = k / ENT;
    i = k % ENT;
    return A'((c / 3) * 256 + (c % 3) * 64 + i * 4);
  endfunction

  // Stream source: presents src_q in order, optional idle gap after each accepted beat
  initial begin
    tvalid = 1'b0;
    tdata  = '0;
    forever begin
      @(negedge clk); #1;
      if (src_fire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        n_consumed++;
        gap_cnt = gap;
      end
      total++;
      if (tready === 1'b1 && (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || busy !== 1'b1)) begin
        bad++;
        $display("FAIL tready_outside_fetch: tready=1 with aw=%0b w=%0b bready=%0b busy=%0b, required tready=0",
                 awvalid, wvalid, bready, busy);
      end
      if (src_q.size() > 0 && gap_cnt == 0) begin
        tvalid = 1'b1;
        tdata  = src_q[0];
      end else begin
        tvalid = 1'b0;
        if (gap_cnt > 0) gap_cnt--;
      end
      src_fire = tvalid && tready;
    end
  end

  // AXI-lite slave with selectable ready ordering, B delay, error injection and stall point
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    forever begin
      @(negedge clk); #1;
      if (rst === 1'b1) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_arm = 0; b_fire = 0;
      end else begin
        if (b_fire) begin
          bvalid = 1'b0; bresp = 2'b00;
          aw_got = 0; w_got = 0; b_arm = 0; b_fire = 0;
          nb++;
        end
        total++;
        if ((awvalid && aw_got) || (wvalid && w_got)) begin
          bad++;
          $display("FAIL one_outstanding: new valid aw=%0b w=%0b before B, required 0 0", awvalid, wvalid);
        end
        if (aw_wait) begin
          total++;
          if (awvalid !== 1'b1 || awaddr !== aw_hold) begin
            bad++;
            $display("FAIL aw_hold: awvalid=%0b awaddr=%0h, required 1 %0h", awvalid, awaddr, aw_hold);
          end
        end
        if (w_wait) begin
          total++;
          if (wvalid !== 1'b1 || wdata !== w_hold) begin
            bad++;
            $display("FAIL w_hold: wvalid=%0b wdata=%0h, required 1 %0h", wvalid, wdata, w_hold);
          end
        end
        if (aw_got) since_aw++;
        if (w_got)  since_w++;
        aw_ok = 1; w_ok = 1;
        if (slave_mode == 1) begin
          if (nb % 2 == 0) aw_ok = w_got && since_w >= 3;
          else             w_ok  = aw_got && since_aw >= 3;
        end
        if (hold_at >= 0 && got_addr.size() == hold_at) aw_ok = 0;
        if (hold_at >= 0 && got_data.size() == hold_at) w_ok  = 0;
        awready = awvalid && !aw_got && aw_ok;
        wready  = wvalid && !w_got && w_ok;
        if (awvalid && awready) begin
          got_addr.push_back(awaddr);
          aw_got = 1; since_aw = 0; aw_wait = 0;
        end else begin
          if (awvalid && !aw_got && !aw_wait) aw_hold = awaddr;
          aw_wait = awvalid && !aw_got;
        end
        if (wvalid && wready) begin
          got_data.push_back(wdata);
          w_got = 1; since_w = 0; w_wait = 0;
          total++;
          if (wstrb !== 4'hF) begin
            bad++;
            $display("FAIL wstrb: got %0h, required f", wstrb);
          end
        end else begin
          if (wvalid && !w_got && !w_wait) w_hold = wdata;
          w_wait = wvalid && !w_got;
        end
        if (aw_got && w_got && !bvalid) begin
          if (!b_arm) begin
            b_arm = 1;
            b_cnt = b_rand ? int'($urandom_range(4, 0)) : 0;
          end
          if (b_cnt == 0) begin
            bvalid = 1'b1;
            bresp  = (nb == err_at) ? 2'b10 : 2'b00;
          end else begin
            b_cnt--;
          end
        end
        b_fire = bvalid && bready;
      end
    end
  end

  task automatic fill_random();
    exp_vals.delete();
    for (int k = 0; k < NWR; k++) exp_vals.push_back($urandom());
  endtask

  // Queue the expected stream, pulse start and wait (bounded) for done
  task automatic run_load(input int gap_in, input bit poke);
    bit timed_out;
    got_addr.delete();
    got_data.delete();
    nb = 0;
    n_consumed = 0;
    gap = gap_in;
    foreach (exp_vals[k]) src_q.push_back(exp_vals[k]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %0b, required 1", busy);
    end
    timed_out = 1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done === 1'b1) begin
        timed_out = 0;
        break;
      end
      start = (poke && (cyc % 37 == 5)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL load_timeout: done never rose, got writes=%0d, required %0d", got_addr.size(), NWR);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, err, tready, awvalid, wvalid, bready} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: busy/done/err/tready/aw/w/bready=%b, required 0000000",
               {busy, done, err, tready, awvalid, wvalid, bready});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || n_consumed !== 0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%0b consumed=%0d, required 0 0", busy, n_consumed);
    end
  endtask

  task automatic test_basic();
    slave_mode = 0; b_rand = 0; err_at = -1; hold_at = -1;
    exp_vals.delete();
    for (int k = 0; k < NWR; k++) exp_vals.push_back(32'((k / ENT) * 100 + (k % ENT)));
    run_load(0, 0);
    total++;
    if (got_addr.size() !== NWR || got_data.size() !== NWR) begin
      bad++;
      $display("FAIL basic_count: got %0d/%0d, required %0d", got_addr.size(), got_data.size(), NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL basic_write[%0d]: got %0h/%0d, required %0h/%0d", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_flags: done/busy/err=%b%b%b, required 100", done, busy, err);
    end
    // Extra beats must stay in the stream while DONE holds
    for (int k = 0; k < 3; k++) src_q.push_back($urandom());
    repeat (10) @(negedge clk);
    total++;
    if (done !== 1'b1 || n_consumed !== NWR) begin
      bad++;
      $display("FAIL done_hold: done=%0b consumed=%0d, required 1 %0d", done, n_consumed, NWR);
    end
    src_q.delete();
  endtask

  task automatic test_alt_ready();
    slave_mode = 1; b_rand = 0; err_at = -1; hold_at = -1;
    fill_random();
    run_load(0, 0);
    total++;
    if (got_addr.size() !== NWR || got_data.size() !== NWR) begin
      bad++;
      $display("FAIL alt_count: got %0d/%0d, required %0d", got_addr.size(), got_data.size(), NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL alt_write[%0d]: got %0h/%0h, required %0h/%0h", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
    slave_mode = 0;
  endtask

  task automatic test_gaps();
    slave_mode = 0; b_rand = 1; err_at = -1; hold_at = -1;
    fill_random();
    run_load(5, 0);
    total++;
    if (got_addr.size() !== NWR || n_consumed !== NWR) begin
      bad++;
      $display("FAIL gap_count: got %0d writes %0d beats, required %0d", got_addr.size(), n_consumed, NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL gap_write[%0d]: got %0h/%0h, required %0h/%0h", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
    gap = 0; b_rand = 0;
  endtask

  task automatic test_bresp_err();
    slave_mode = 0; b_rand = 0; err_at = 17; hold_at = -1;
    fill_random();
    run_load(0, 0);
    total++;
    if (err !== 1'b1 || got_addr.size() !== NWR) begin
      bad++;
      $display("FAIL err_load: err=%0b writes=%0d, required 1 %0d", err, got_addr.size(), NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL err_write[%0d]: got %0h/%0h, required %0h/%0h", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
    err_at = -1;
    fill_random();
    run_load(0, 0);
    total++;
    if (err !== 1'b0 || got_addr.size() !== NWR) begin
      bad++;
      $display("FAIL err_cleared: err=%0b writes=%0d, required 0 %0d", err, got_addr.size(), NWR);
    end
  endtask

  task automatic test_reset_mid();
    int held;
    bit found;
    slave_mode = 0; b_rand = 0; err_at = -1; hold_at = 40;
    fill_random();
    got_addr.delete(); got_data.delete(); nb = 0; n_consumed = 0; gap = 0;
    foreach (exp_vals[k]) src_q.push_back(exp_vals[k]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (got_addr.size() == 40 && awvalid === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reach40: got writes=%0d awvalid=%0b, required 40 1", got_addr.size(), awvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, err, tready, awvalid, wvalid, bready} !== 7'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: busy/done/err/tready/aw/w/bready=%b, required 0000000",
               {busy, done, err, tready, awvalid, wvalid, bready});
    end
    rst = 1'b0;
    hold_at = -1;
    held = n_consumed;
    repeat (6) @(negedge clk);
    total++;
    if (n_consumed !== held || busy !== 1'b0 || tready !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle: consumed=%0d busy=%0b tready=%0b, required %0d 0 0", n_consumed, busy, tready, held);
    end
    src_q.delete();
    fill_random();
    run_load(0, 0);
    total++;
    if (got_addr.size() !== NWR) begin
      bad++;
      $display("FAIL mid_reload_count: got %0d, required %0d", got_addr.size(), NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL mid_reload_write[%0d]: got %0h/%0h, required %0h/%0h", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    slave_mode = 0; b_rand = 1; err_at = -1; hold_at = -1;
    fill_random();
    run_load(0, 1);
    total++;
    if (got_addr.size() !== NWR || n_consumed !== NWR) begin
      bad++;
      $display("FAIL poke_count: got %0d writes %0d beats, required %0d", got_addr.size(), n_consumed, NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL poke_write[%0d]: got %0h/%0h, required %0h/%0h", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
    fill_random();
    run_load(0, 0);
    total++;
    if (got_addr.size() !== NWR || done !== 1'b1) begin
      bad++;
      $display("FAIL second_load: writes=%0d done=%0b, required %0d 1", got_addr.size(), done, NWR);
    end
    for (int k = 0; k < NWR && k < got_addr.size() && k < got_data.size(); k++) begin
      total++;
      if (got_addr[k] !== model_addr(k) || got_data[k] !== exp_vals[k]) begin
        bad++;
        $display("FAIL second_write[%0d]: got %0h/%0h, required %0h/%0h", k, got_addr[k], got_data[k],
                 model_addr(k), exp_vals[k]);
      end
    end
    b_rand = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_alt_ready();
    test_gaps();
    test_bresp_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
